conv_seq_ctrl: RTL and testbench
================================

// Module: conv_seq_ctrl
// PURPOSE
//  Sequencer for the 1-D convolution datapath: XMEM/FMEM read ports, the registered multiplier and the accumulator.
//  After XMEM holds a full N-sample vector, it walks every output window, issuing addresses and pipeline enables.
//  It presents each finished sum on the output valid/ready handshake and pulses conv_done when all outputs are accepted.
//  Sits between the XMEM write controller (conv_start) and the MAC unit and output port.
// PARAMETERS
//  N    30   input vector length (XMEM depth)
//  M    9    filter taps (FMEM depth)
//  T    11   datapath width; informational only, carries no data here
//  P    1    MACs per output; only P=1 is supported, other values are an elaboration $error
// PORTS
//  clk          in   1              rising-edge clock
//  reset_n      in   1              asynchronous, active-low reset
//  conv_start   in   1              XMEM full; sampled only in IDLE
//  xmem_addr    out  $clog2(N)      XMEM read address
//  fmem_addr    out  $clog2(M)      FMEM ROM read address
//  mult_en      out  1              load the product register (read data valid)
//  accum_clr    out  1              accumulator loads the product instead of adding it
//  accum_en     out  1              accumulator register enable
//  m_valid_y    out  1              accumulator output valid
//  m_ready_y    in   1              downstream ready
//  conv_done    out  1              one-cycle pulse after the last output handshake
// BEHAVIOUR
//  Reset (async, reset_n=0): all outputs are 0, state=IDLE, counters=0. A reset mid-operation aborts with no conv_done.
//  NOUT = N-M+1 (22). Output j = sum over k=0..M-1 of x[j+k]*f[k].
//  FSM states and transitions:
//   IDLE:  if conv_start, set j=0 and k=0, go to MAC. conv_start in any other state is ignored.
//   MAC:   each cycle drive xmem_addr=j+k and fmem_addr=k, then k++. When k=M-1, go to DRAIN.
//   DRAIN: 2 cycles, flushing the memory-read and multiplier stages, then go to OUT.
//   OUT:   m_valid_y=1 and held until m_ready_y. On handshake:
//           - j<NOUT-1: j++, k=0, go to MAC.
//           - j=NOUT-1: conv_done=1 for 1 cycle, go to IDLE.
//  Pipeline, 2-bit shift register of issue valids:
//   - mult_en is asserted 1 cycle after an address issue.
//   - accum_en is asserted 2 cycles after the issue.
//   - accum_clr = accum_en for tap k=0 only.
//   - m_valid_y rises the cycle after the last accum_en.
//  Throughput: M+3 cycles per output with m_ready_y tied high. Addresses are not issued during DRAIN or OUT.
//  m_ready_y while m_valid_y=0 is ignored. m_valid_y never drops without a handshake.
//  Address max: xmem_addr = N-1 at (j=NOUT-1, k=M-1); no wrap. fmem_addr wraps only via the k reset.
//  conv_done and conv_start in the same cycle: conv_done takes effect; the start is taken in IDLE the next cycle if still high.
// CONFIGURATION
//  CONV_STALL_CNT_EN defined:
//   - adds output port stall_cnt [15:0].
//   - stall_cnt increments on every cycle with m_valid_y && !m_ready_y, and saturates at 16'hFFFF.
//   - it clears on the IDLE->MAC transition and is reset to 0.
//  Not defined: the port and the counter are absent; behaviour is otherwise identical.
// STRUCTURE
//  conv_pkg:
//   - state_t enum {IDLE, MAC, DRAIN, OUT}.
//   - localparams NOUT, XAW=$clog2(N), FAW=$clog2(M), PIPE_LAT=2.
//  Sub-module conv_addr_gen holds the window counter j and the tap counter k.
//   - inputs: clr, step_k, step_j.
//   - outputs: xmem_addr, fmem_addr, last_k, last_j.
//  The FSM, pipeline valid shift register and handshake live in conv_seq_ctrl.
// TESTING
//  1. conv_start pulse, m_ready_y=1:
//     - 22 handshakes occur, m_valid_y first rises 12 cycles after the start is taken.
//     - conv_done pulses exactly once; the sums match a golden model for x=0..29, f=1..9.
//  2. m_ready_y low 5 cycles per output: m_valid_y is held and no new addresses are issued.
//     With the macro, stall_cnt=110 at done.
//  3. Address trace for j=21: xmem_addr 21..29, fmem_addr 0..8; accum_clr only on the tap-0 accum_en.
//  4. reset_n low during output 7:
//     - all outputs go to 0 asynchronously, with no conv_done.
//     - a new conv_start then reruns all 22 outputs.
//  5. conv_start held high throughout:
//     - no restart mid-run.
//     - a second 22-output run begins 1 cycle after conv_done.
//  6. m_ready_y=1 from reset with conv_start=0: m_valid_y stays 0 and no enables are asserted.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the 1-D convolution sequencer.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

    localparam int CONV_N   = 30;
    localparam int CONV_M   = 9;
    localparam int NOUT     = CONV_N - CONV_M + 1;
    localparam int XAW      = $clog2(CONV_N);
    localparam int FAW      = $clog2(CONV_M);
    localparam int PIPE_LAT = 2;

endpackage

// File: rtl/conv_addr_gen.sv
// Window (j) and tap (k) counters; the XMEM address is j+k, the FMEM address is k.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int N = CONV_N,
    parameter int M = CONV_M
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 step_k,
    input  logic                 step_j,
    output logic [$clog2(N)-1:0] xmem_addr,
    output logic [$clog2(M)-1:0] fmem_addr,
    output logic                 last_k,
    output logic                 last_j
);
    localparam int XW = $clog2(N);
    localparam int FW = $clog2(M);
    localparam int NO = N - M + 1;

    logic [XW-1:0] r_j;
    logic [FW-1:0] r_k;

    // Advancing the window always restarts the tap counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_j <= '0;
            r_k <= '0;
        end else if (clr) begin
            r_j <= '0;
            r_k <= '0;
        end else if (step_j) begin
            r_j <= r_j + XW'(1);
            r_k <= '0;
        end else if (step_k) begin
            r_k <= r_k + FW'(1);
        end
    end

    assign xmem_addr = r_j + XW'(r_k);
    assign fmem_addr = r_k;
    assign last_k    = (r_k == FW'(M - 1));
    assign last_j    = (r_j == XW'(NO - 1));

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: walks all output windows, drives memory/MAC enables, output handshake.
// Optional CONV_STALL_CNT_EN adds a saturating stall_cnt output.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int N = CONV_N,
    parameter int M = CONV_M,
    parameter int T = 11,
    parameter int P = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 conv_start,
    output logic [$clog2(N)-1:0] xmem_addr,
    output logic [$clog2(M)-1:0] fmem_addr,
    output logic                 mult_en,
    output logic                 accum_clr,
    output logic                 accum_en,
    output logic                 m_valid_y,
    input  logic                 m_ready_y,
    output logic                 conv_done
`ifdef CONV_STALL_CNT_EN
   ,output logic [15:0]          stall_cnt
`endif
);
    if (P != 1 || T < 1) begin : g_bad_cfg
        $error("conv_seq_ctrl: only P=1 with T>=1 is supported");
    end

    state_t              r_state;
    logic [1:0]          r_drain_cnt;
    logic                r_m_valid;
    logic                r_done;
    logic [PIPE_LAT-1:0] r_vld_pipe;
    logic [PIPE_LAT-1:0] r_clr_pipe;

    logic w_last_k, w_last_j, w_clr, w_issue, w_step_k, w_step_j, w_hs;

    assign w_issue  = (r_state == MAC);
    assign w_step_k = w_issue && !w_last_k;
    assign w_hs     = r_m_valid && m_ready_y;
    assign w_step_j = w_hs && !w_last_j;
    // A start coinciding with the done pulse is deferred one cycle.
    assign w_clr    = (r_state == IDLE) && conv_start && !r_done;

    conv_addr_gen #(.N(N), .M(M)) u_addr_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (w_clr),
        .step_k    (w_step_k),
        .step_j    (w_step_j),
        .xmem_addr (xmem_addr),
        .fmem_addr (fmem_addr),
        .last_k    (w_last_k),
        .last_j    (w_last_j)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_drain_cnt <= '0;
            r_m_valid   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (w_clr) r_state <= MAC;
                MAC: if (w_last_k) begin
                    r_state     <= DRAIN;
                    r_drain_cnt <= '0;
                end
                DRAIN: if (r_drain_cnt == 2'(PIPE_LAT - 1)) begin
                    r_state   <= OUT;
                    r_m_valid <= 1'b1;
                end else begin
                    r_drain_cnt <= r_drain_cnt + 2'd1;
                end
                OUT: if (m_ready_y) begin
                    r_m_valid <= 1'b0;
                    if (w_last_j) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= MAC;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Issue valids ride behind the address: stage 0 = read data ready, last stage = product ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe <= '0;
            r_clr_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[PIPE_LAT-2:0], w_issue};
            r_clr_pipe <= {r_clr_pipe[PIPE_LAT-2:0], w_issue && (fmem_addr == '0)};
        end
    end

    assign mult_en   = r_vld_pipe[0];
    assign accum_en  = r_vld_pipe[PIPE_LAT-1];
    assign accum_clr = r_clr_pipe[PIPE_LAT-1];
    assign m_valid_y = r_m_valid;
    assign conv_done = r_done;

`ifdef CONV_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_clr) begin
            r_stall_cnt <= '0;
        end else if (r_m_valid && !m_ready_y && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: behavioural XMEM/FMEM/MAC datapath plus a sum scoreboard.
module tb_conv_seq_ctrl;
    localparam int N    = 30;
    localparam int M    = 9;
    localparam int NOUT = N - M + 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       conv_start = 1'b0;
    logic [4:0] xmem_addr;
    logic [3:0] fmem_addr;
    logic       mult_en, accum_clr, accum_en, m_valid_y, conv_done;
    logic       m_ready_y = 1'b0;
`ifdef CONV_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    conv_seq_ctrl #(.N(N), .M(M), .T(11), .P(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .conv_start (conv_start),
        .xmem_addr  (xmem_addr),
        .fmem_addr  (fmem_addr),
        .mult_en    (mult_en),
        .accum_clr  (accum_clr),
        .accum_en   (accum_en),
        .m_valid_y  (m_valid_y),
        .m_ready_y  (m_ready_y),
        .conv_done  (conv_done)
`ifdef CONV_STALL_CNT_EN
       ,.stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int hs_cnt  = 0;
    int done_cnt = 0;
    int q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: x[i]=i, f[k]=k+1, synchronous reads, product register, accumulator.
    int xd, fd, prod, acc;
    always @(posedge clk) begin
        xd <= int'(xmem_addr);
        fd <= int'(fmem_addr) + 1;
        if (mult_en) prod <= xd * fd;
        if (accum_en) acc <= accum_clr ? prod : acc + prod;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic push_run();
        for (int j = 0; j < NOUT; j++) begin
            int s = 0;
            for (int k = 0; k < M; k++) s += (j + k) * (k + 1);
            q.push_back(s);
        end
    endtask

    task automatic pulse_start(output int t0);
        @(posedge clk); #1 conv_start = 1'b1; t0 = cyc;
        @(posedge clk); #1 conv_start = 1'b0;
    endtask

    task automatic wait_valid(output bit ok, output int at);
        ok = 1'b0; at = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (m_valid_y) begin ok = 1'b1; at = cyc; return; end
        end
        fail_msg("wait_valid timeout");
    endtask

    task automatic wait_done(output bit ok, output int at);
        ok = 1'b0; at = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (conv_done) begin ok = 1'b1; at = cyc; return; end
        end
        fail_msg("wait_done timeout");
    endtask

    task automatic settle_and_check(input string tag, input int d0, input int exp_done);
        repeat (20) @(negedge clk);
        chk({tag, " done pulses"}, done_cnt - d0, exp_done);
        chk({tag, " scoreboard empty"}, q.size(), 0);
    endtask

    // Monitor: scoreboard pops, address/enable trace, handshake invariants.
    initial begin
        int tj = 0, tk = 0, ak = 0;
        logic pv = 1'b0, pr = 1'b0;
        logic [4:0] px = '0;
        logic [3:0] pf = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                tj = 0; tk = 0; ak = 0; pv = 1'b0; pr = 1'b0;
            end else begin
                if (m_valid_y && m_ready_y) begin
                    hs_cnt++;
                    if (q.size() == 0) fail_msg("unexpected output handshake");
                    else chk("y sum", acc, q.pop_front());
                end
                if (pv && !pr) chk("m_valid_y held until handshake", m_valid_y, 1);
                if (m_valid_y && (mult_en || accum_en)) fail_msg("enable asserted while output pending");
                if (mult_en) begin
                    chk("fmem_addr issued", pf, tk);
                    chk("xmem_addr issued", px, tj + tk);
                    tk++;
                    if (tk == M) begin tk = 0; tj = (tj == NOUT - 1) ? 0 : tj + 1; end
                end
                if (accum_en) begin
                    chk("accum_clr on tap 0 only", accum_clr, (ak == 0));
                    ak = (ak == M - 1) ? 0 : ak + 1;
                end else if (accum_clr) begin
                    fail_msg("accum_clr without accum_en");
                end
                if (conv_done) done_cnt++;
                pv = m_valid_y; pr = m_ready_y; px = xmem_addr; pf = fmem_addr;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired: %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int t0, tv, td, d0, base;

        // Reset state
        #2;
        chk("reset outputs", {xmem_addr, fmem_addr, mult_en, accum_clr, accum_en, m_valid_y, conv_done}, 0);
`ifdef CONV_STALL_CNT_EN
        chk("reset stall_cnt", stall_cnt, 0);
`endif
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;

        // Idle with ready high and no start: nothing moves
        m_ready_y = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle quiet", {m_valid_y, mult_en, accum_en, accum_clr, conv_done}, 0);
        end

        // Single start pulse, ready tied high: latency, throughput, sums, one done
        d0 = done_cnt;
        push_run();
        pulse_start(t0);
        wait_valid(ok, tv);
        if (ok) chk("first valid latency", tv - t0, 12);
        wait_done(ok, td);
        if (ok) chk("done cycle (M+3 per output)", td - t0, 12 + 12 * (NOUT - 1) + 1);
        settle_and_check("run1", d0, 1);

        // Ready low 5 cycles per output
        m_ready_y = 1'b0;
        d0 = done_cnt;
        push_run();
        pulse_start(t0);
        for (int o = 0; o < NOUT; o++) begin
            wait_valid(ok, tv);
            if (!ok) break;
            for (int s = 1; s < 5; s++) begin
                @(negedge clk);
                chk("valid held while stalled", m_valid_y, 1);
            end
            @(posedge clk); #1 m_ready_y = 1'b1;
            @(posedge clk); #1 m_ready_y = 1'b0;
        end
        wait_done(ok, td);
`ifdef CONV_STALL_CNT_EN
        chk("stall_cnt at done", stall_cnt, 5 * NOUT);
`endif
        settle_and_check("stall run", d0, 1);

        // Reset during output 7, then full rerun
        m_ready_y = 1'b1;
        d0 = done_cnt;
        push_run();
        pulse_start(t0);
        base = hs_cnt;
        for (int i = 0; i < 400 && hs_cnt < base + 7; i++) @(negedge clk);
        repeat (4) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("async reset outputs", {xmem_addr, fmem_addr, mult_en, accum_clr, accum_en, m_valid_y, conv_done}, 0);
        q.delete();
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no done after abort", done_cnt - d0, 0);
        chk("outputs idle after abort", {m_valid_y, mult_en, accum_en}, 0);
        push_run();
        pulse_start(t0);
        wait_done(ok, td);
        settle_and_check("rerun", d0, 1);

        // Start held high: back-to-back runs, restart one cycle after done
        d0 = done_cnt;
        push_run();
        push_run();
        @(posedge clk); #1 conv_start = 1'b1;
        wait_done(ok, td);
        chk("no restart mid-run", q.size(), NOUT);
        wait_valid(ok, tv);
        if (ok) chk("second run first valid after done", tv - td, 13);
        @(posedge clk); #1 conv_start = 1'b0;
        wait_done(ok, td);
        settle_and_check("held start", d0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
